// File: rtl/mul_self_shift.sv
// ============================================================================
// mul_self_shift : iterative shift-add multiplier for MULT/MULTU (HI/LO path)
// Optional build macro: MUL_EARLY_OUT_EN (finish once the multiplier is spent)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_self_shift #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 valid,
  input  logic                 sign,
  input  logic                 flush,
  output logic                 mul_stall,
  output logic                 mul_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sign_save_q, sign_save_d;
  logic                   a_msb_q, a_msb_d;
  logic                   b_msb_q, b_msb_d;
  logic                   done_q, done_d;

  logic [WIDTH-1:0]       a_abs;
  logic [WIDTH-1:0]       b_abs;
  logic                   last_iter;
  logic                   neg;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude for the most negative operand.
  assign a_abs = (sign && a[WIDTH-1]) ? (~a + C_ONE) : a;
  assign b_abs = (sign && b[WIDTH-1]) ? (~b + C_ONE) : b;

`ifdef MUL_EARLY_OUT_EN
  assign last_iter = (cnt_q == C_LAST) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_q == C_LAST);
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    sign_save_d = sign_save_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid && !flush) begin
          sign_save_d = sign;
          a_msb_d     = a[WIDTH-1];
          b_msb_d     = b[WIDTH-1];
          mcand_d     = {{WIDTH{1'b0}}, a_abs};
          mplier_d    = b_abs;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          // Abort wins over a coincident completion: no done, cleared result.
          acc_d   = '0;
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      sign_save_q <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      sign_save_q <= sign_save_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      done_q      <= done_d;
    end
  end

  assign neg       = sign_save_q & (a_msb_q ^ b_msb_q);
  assign result    = neg ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  assign mul_stall = (state_q == RUN);
  assign mul_done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_self_shift.sv
// ============================================================================
// tb_mul_self_shift : directed self-checking bench for mul_self_shift
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mul_self_shift;

`ifdef MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int MAX_WAIT = 100;

  logic        clk;
  logic        resetn;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid;
  logic        sign;
  logic        flush;
  logic        mul_stall;
  logic        mul_done;
  logic [63:0] result;

  int n_checks = 0;
  int n_errors = 0;

  mul_self_shift #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .sign      (sign),
    .flush     (flush),
    .mul_stall (mul_stall),
    .mul_done  (mul_done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Counts stall-high cycles (sampled on negedges) until stall drops.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      if (!mul_stall) return;
      cycles++;
    end
    check_eq("wait_timeout", 64'(cycles), 64'(MAX_WAIT + 1));
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic s);
    @(negedge clk);
    a     = av;
    b     = bv;
    sign  = s;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input logic [63:0] exp, input int early_cyc);
    int cyc;
    start_op(av, bv, s);
    wait_idle(cyc);
    check_eq({tag, "_cycles"}, 64'(cyc), 64'(EARLY ? early_cyc : 32));
    check_eq({tag, "_done"}, {63'b0, mul_done}, 64'd1);
    check_eq({tag, "_result"}, result, exp);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {63'b0, mul_done}, 64'd0);
    check_eq({tag, "_hold"}, result, exp);
  endtask

  initial begin
    int cyc;
    resetn = 1'b0;
    a = '0; b = '0; valid = 1'b0; sign = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_stall", {63'b0, mul_stall}, 64'd0);
    check_eq("rst_done", {63'b0, mul_done}, 64'd0);
    check_eq("rst_result", result, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    run_op("u_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 32);
    run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 3);
    run_op("u_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 3);
    run_op("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 32);
    run_op("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("s_7xm2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 2);
    run_op("u_b3", 32'h1234_5678, 32'd3, 1'b0, 64'h0000_0000_369D_0368, 2);
    run_op("u_b0", 32'hDEAD_BEEF, 32'd0, 1'b0, 64'h0, 1);
    run_op("u_bmsb", 32'd3, 32'h8000_0000, 1'b0, 64'h0000_0001_8000_0000, 32);

    // Flush on the 10th RUN cycle.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check_eq("fl_running", {63'b0, mul_stall}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("fl_stall", {63'b0, mul_stall}, 64'd0);
    check_eq("fl_done", {63'b0, mul_done}, 64'd0);
    check_eq("fl_result", result, 64'd0);
    @(negedge clk);
    check_eq("fl_done_late", {63'b0, mul_done}, 64'd0);
    run_op("after_fl", 32'd7, 32'd6, 1'b0, 64'h2A, 3);

    // Flush coinciding with the final iteration edge.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (31) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flc_stall", {63'b0, mul_stall}, 64'd0);
    check_eq("flc_done", {63'b0, mul_done}, 64'd0);
    check_eq("flc_result", result, 64'd0);

    // valid held high through completion: ignored in RUN, re-accepted after.
    @(negedge clk);
    a = 32'd7; b = 32'd6; sign = 1'b0; valid = 1'b1;
    wait_idle(cyc);
    check_eq("b2b_first", result, 64'h2A);
    check_eq("b2b_first_done", {63'b0, mul_done}, 64'd1);
    a = 32'd5; b = 32'd5;
    @(negedge clk);
    valid = 1'b0;
    check_eq("b2b_accept", {63'b0, mul_stall}, 64'd1);
    wait_idle(cyc);
    check_eq("b2b_second", result, 64'h19);

    // Asynchronous reset mid-operation.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_eq("ar_running", {63'b0, mul_stall}, 64'd1);
    resetn = 1'b0;
    #1;
    check_eq("ar_stall", {63'b0, mul_stall}, 64'd0);
    check_eq("ar_result", result, 64'd0);
    check_eq("ar_done", {63'b0, mul_done}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ar_idle", {63'b0, mul_stall}, 64'd0);
    check_eq("ar_idle_result", result, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_self_shift.md
Name: mul_self_shift

Overview:
- Iterative 32x32 shift-add multiplier for the MIPS32 execute stage. It serves MULT and MULTU and is the multiply counterpart of the iterative divider.
- Operands are converted to absolute values at start. One partial-product add is done per cycle.
- Sign correction is applied combinationally on the output, and the 64-bit {hi,lo} result is driven to the HI/LO path.
- The block stalls the pipeline while busy and supports a pipeline flush.

Parameters:
- WIDTH, 32, operand width. The result is 2*WIDTH. Only 32 is required to be supported.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- resetn  input  1  asynchronous active-low reset
- a  input  32  multiplicand
- b  input  32  multiplier
- valid  input  1  start request, sampled when idle
- sign  input  1  1: signed (MULT), 0: unsigned (MULTU)
- flush  input  1  synchronous abort of the current operation (exception/branch flush)
- mul_stall  output  1  high while an operation is in progress
- mul_done  output  1  one-cycle pulse on the cycle after the final iteration edge
- result  output  64  {hi[63:32], lo[31:0]}; stable from mul_done until the next accept

Behaviour:
- Reset (resetn low, asynchronous):
  - busy=0, mul_stall=0, mul_done=0.
  - Accumulator=0, sign_save=0, a_save=0, b_save=0, so result=0.
  - Reset mid-operation abandons the operation immediately.
- States: IDLE, RUN.
- IDLE, accept edge: if valid=1 and flush=0 on an edge:
  - Latch a_save=a, b_save=b, sign_save=sign.
  - Set mcand (64 bit) = {32'b0, |a|} and mplier (32 bit) = |b|.
    - |x| = ~x+1 when sign & x[31], else x.
  - Set acc=0, cnt=0, mul_stall=1, then go to RUN.
  - valid=0 or flush=1: remain in IDLE.
- RUN, each edge:
  - if mplier[0], acc <= acc + mcand (64-bit, no overflow possible);
  - mcand <= mcand<<1;
  - mplier <= mplier>>1;
  - cnt <= cnt+1.
  - On the edge where cnt==31 (iteration 32): go to IDLE, set mul_stall=0, and set mul_done=1 for exactly the next cycle.
- Latency: mul_stall is high for exactly 32 cycles after the accept edge. mul_done is asserted in cycle 33.
- valid while in RUN: ignored.
- valid still high in the first IDLE cycle after completion: a new operation is accepted. The consumer deasserts valid on mul_done.
- flush in RUN:
  - The next edge goes to IDLE, sets mul_stall=0 and acc=0.
  - No mul_done is generated, and no new accept happens on that edge.
- flush together with completion on the same edge: flush wins, so mul_done stays 0 and acc=0.
- result, combinational:
  - neg = sign_save & (a_save[31] ^ b_save[31]).
  - result = neg ? ~acc+1 : acc.
  - Result is valid only when mul_stall=0.
- Corner case: 0x80000000 signed gives |x|=0x80000000, which is correct as an unsigned magnitude.

Optional Feature:
- MUL_EARLY_OUT_EN
- Defined: completion also occurs on the RUN edge where the shifted mplier becomes 0 (i.e. mplier>>1 == 0), even when cnt<31.
  - The stall length is then max(1, index of the highest set bit of |b| + 1) cycles.
  - b=0 gives a 1-cycle stall.
  - mul_done, flush and result rules are unchanged.
- Undefined: a fixed 32-cycle stall regardless of operands.

Test Plan:
- Unsigned a=0xFFFFFFFF, b=0xFFFFFFFF, valid one cycle -> mul_stall high for 32 cycles, mul_done pulse, result=0xFFFFFFFE_00000001.
- Signed a=0xFFFFFFFD (-3), b=5 -> result=0xFFFFFFFF_FFFFFFF1. Same operands unsigned -> result=0x00000004_FFFFFFF1.
- Signed a=0x80000000, b=0x80000000 -> result=0x40000000_00000000. Signed a=0x80000000, b=1 -> result=0xFFFFFFFF_80000000.
- Flush asserted on the 10th RUN cycle -> mul_stall low the next cycle, no mul_done, result=0. Then a=7, b=6 -> result=0x00000000_0000002A after 32 cycles.
- resetn low mid-operation (cycle 15) -> mul_stall=0, result=0 immediately. Release resetn with valid=0 -> stays idle.
- MUL_EARLY_OUT_EN defined: b=3 -> 2-cycle stall; b=0 -> 1-cycle stall with result=0; b=0x80000000 unsigned -> 32 cycles. Undefined: all three take 32 cycles with identical results.
